// File: rtl/bram_interface.sv
// Capture/playback wrapper around an inferred simple-dual-port block RAM.
// After reset it captures RAM_DEPTH consecutive samples, then replays them
// once in address order and holds the last word until the next reset.
module bram_interface #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 307200
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [RAM_WIDTH-1:0] iData,
    output logic [RAM_WIDTH-1:0] oData
);

    // A depth of 1 would give a zero-width address; keep at least one bit.
    localparam int ADDR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic                  writeEn;
    logic                  readEn;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [RAM_WIDTH-1:0]  ramQ;
    logic [RAM_WIDTH-1:0]  mem [RAM_DEPTH];

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and RAM strobes: one write per WRITE cycle, one read per READ cycle.
    always_comb begin
        stateNext = state;
        writeEn   = 1'b0;
        readEn    = 1'b0;
        case (state)
            IDLE: begin
                stateNext = WRITE;
            end
            WRITE: begin
                writeEn = 1'b1;
                if (wrAddr == LAST_ADDR) begin
                    stateNext = READ;
                end
            end
            READ: begin
                readEn = 1'b1;
                if (rdAddr == LAST_ADDR) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = DONE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Address counters; they stop at the last address instead of wrapping.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrAddr <= '0;
            rdAddr <= '0;
        end else begin
            if (writeEn && (wrAddr != LAST_ADDR)) begin
                wrAddr <= wrAddr + 1'b1;
            end
            if (readEn && (rdAddr != LAST_ADDR)) begin
                rdAddr <= rdAddr + 1'b1;
            end
        end
    end

    // RAM write port; contents survive reset, a reset edge blocks the write.
    always_ff @(posedge iClk) begin
        if (writeEn && !iRst) begin
            mem[wrAddr] <= iData;
        end
    end

    // RAM registered read port; holds its value once reading stops.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            ramQ <= '0;
        end else if (readEn) begin
            ramQ <= mem[rdAddr];
        end
    end

    // Output register: second stage of the two-cycle read latency.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData <= '0;
        end else begin
            oData <= ramQ;
        end
    end

endmodule

// File: tb/tb_bram_interface.sv
// Directed bench for bram_interface with a 100-word RAM.
module tb_bram_interface;

    localparam int W = 8;
    localparam int N = 100;

    logic         iClk;
    logic         iRst;
    logic [W-1:0] iData;
    logic [W-1:0] oData;

    int checks;
    int fails;

    bram_interface #(
        .RAM_WIDTH (W),
        .RAM_DEPTH (N)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iData (iData),
        .oData (oData)
    );

    // Clock generation
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Data pattern for word k of each capture mode.
    function automatic logic [W-1:0] pat(input int mode, input int k);
        logic [W-1:0] v;
        case (mode)
            0: v = W'(k + 1);
            1: begin
                case (k % 4)
                    0: v = 8'hFF;
                    1: v = 8'h00;
                    2: v = 8'hAA;
                    default: v = 8'h55;
                endcase
            end
            2: v = W'(8'h80 + k);
            3: v = W'(8'h10 + k);
            default: v = 8'h33;
        endcase
        return v;
    endfunction

    // Drive inputs, take one rising edge, then check oData on the falling edge.
    task automatic doEdge(input logic [W-1:0] d, input logic r,
                          input logic [W-1:0] exp, input string tag, input int e);
        iData = d;
        iRst  = r;
        @(posedge iClk);
        @(negedge iClk);
        checks++;
        assert (oData === exp) else begin
            fails++;
            $error("FAIL %s edge %0d: oData=%h expected %h", tag, e, oData, exp);
        end
    endtask

    // One capture/replay run starting at E0; abortEdge >= 0 applies reset there.
    task automatic runCycle(input int mode, input int abortEdge, input string tag);
        logic [W-1:0] d;
        logic [W-1:0] exp;
        for (int e = 0; e <= 2 * N + 11; e++) begin
            if (e == abortEdge) begin
                doEdge(8'hC3, 1'b1, 8'h00, {tag, "_rst"}, e);
                return;
            end
            if (e >= 1 && e <= N)  d = pat(mode, e - 1);
            else if (e > 2 * N + 1) d = 8'hFF;
            else                    d = W'($urandom_range(0, 255));
            if (e <= N + 1)         exp = 8'h00;
            else if (e <= 2 * N + 1) exp = pat(mode, e - N - 2);
            else                    exp = pat(mode, N - 1);
            doEdge(d, 1'b0, exp, tag, e);
        end
    endtask

    // Directed sequence
    initial begin
        checks = 0;
        fails  = 0;
        iRst   = 1'b1;
        iData  = '0;

        for (int i = 0; i < 5; i++) doEdge(8'h5A, 1'b1, 8'h00, "reset", i);

        runCycle(0, -1, "count");
        doEdge(8'h00, 1'b1, 8'h00, "rst_after_done", 0);

        runCycle(1, -1, "fullrange");
        doEdge(8'h00, 1'b1, 8'h00, "rst_after_done", 0);

        runCycle(4, 50, "midwrite");
        runCycle(2, -1, "after_midwrite");
        doEdge(8'h00, 1'b1, 8'h00, "rst_after_done", 0);

        runCycle(0, 150, "midread");
        runCycle(3, -1, "after_midread");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/bram_interface.md
Name: bram_interface

Overview:
- Self-sequencing capture/playback wrapper around an inferred single-clock simple-dual-port block RAM.
- After reset it captures exactly RAM_DEPTH consecutive input samples (one per clock) into addresses 0..RAM_DEPTH-1.
- It then streams the stored samples back out in address order, once.
- Sits between a pixel/byte source (e.g. 640x480 8-bit image stream) and downstream logic that needs a buffered replay.

Parameters:
- RAM_WIDTH, 8, data width of iData, oData and each RAM word.
- RAM_DEPTH, 307200, number of words captured and replayed (640x480). Benches override to a small value (e.g. 100).
- ADDR_WIDTH (localparam), $clog2(RAM_DEPTH), address counter width.

Ports:
- iClk  input  1  system clock; all logic on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iData  input  RAM_WIDTH  sample stream; sampled every WRITE-state edge.
- oData  output  RAM_WIDTH  replayed sample stream, registered.

Behaviour:
- Single clock domain: one clock; reset is synchronous and active-high. iRst=1 at a rising edge forces the reset state.
- Reset values: state=IDLE, write address=0, read address=0, RAM read-data register=0, oData=0.
- RAM contents are not cleared by reset.
- FSM states: IDLE, WRITE, READ, DONE.
- E0 is the first rising edge with iRst=0. Ek is the k-th edge after E0.
- IDLE: at E0 go to WRITE. No write at E0.
- WRITE: at E1..E_N (N=RAM_DEPTH), write iData sampled at that edge into address k-1, then increment the write address.
- Leaving WRITE: at E_N the last word goes to address N-1 and the state goes to READ with read address=0. The write address does not wrap.
- READ: each edge issues a RAM read of the current read address and increments it, addresses 0..N-1 at E_{N+1}..E_{2N}.
- Read latency is 2 cycles: registered RAM output (1) plus output register (1).
- Stored word k appears on oData after edge E_{N+2+k}, k=0..N-1, one new word per cycle with no gaps.
- After the read of address N-1 is issued, the state goes to DONE.
- DONE:
  - No further reads or writes.
  - oData holds the last word (address N-1) until reset.
  - iData is ignored.
- oData is 0 from reset until the first replayed word appears. It is never X after reset.
- iData is ignored in IDLE, READ and DONE.
- Reset mid-WRITE or mid-READ returns to IDLE on that edge and oData goes to 0. A new capture restarts at address 0 and overwrites old contents.
- RAM: inferred simple dual-port, synchronous write, synchronous registered read. Write and read never target the same address in the same cycle.

Test Plan:
- Reset check (RAM_DEPTH=100): hold iRst=1 for 5 cycles, then release -> oData=0 through E_{101}.
- Capture/replay: drive iData=k+1 (0x01..0x64) at E1..E100 -> oData = 0x01..0x64 after E102..E201 respectively, 0 mismatches.
- Hold after done: continue 10 cycles with iData=0xFF -> oData stays 0x64; a new reset is required to restart.
- Full-range data: drive iData=0xFF,0x00,0xAA,0x55 repeating -> replay is bit-exact, including the 0x00 and 0xFF words.
- Reset mid-write: assert iRst at E50 for 1 cycle, then capture the pattern 0x80+k -> replay is 0x80..0xE3 only; no stale data appears.
- Reset mid-read: assert iRst at E150, re-capture 0x10+k -> oData=0 at the reset edge, then replays 0x10..0x73 at the required edges.
